// File: rtl/mult_pkg.sv
// Shared definitions for the sequential signed multiplier: default widths and FSM states.
package mult_pkg;

    localparam int unsigned M_DEF = 16;
    localparam int unsigned N_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mult_seq_dp.sv
// Shift-and-add datapath: operand registers, accumulator and the single add/subtract.
module mult_seq_dp
    import mult_pkg::*;
#(
    parameter int unsigned M  = M_DEF,
    parameter int unsigned N  = N_DEF,
    parameter int unsigned CW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_c,
    input  logic            step_c,
    input  logic [M-1:0]    a,
    input  logic [N-1:0]    b,
    input  logic [CW-1:0]   cnt,
    output logic [M+N-1:0]  p
);

    localparam int unsigned W = M + N;

    logic [W-1:0] a_ext_q, a_ext_d;
    logic [N-1:0] b_q, b_d;
    logic [W-1:0] acc_q, acc_d;
    logic [W-1:0] p_q, p_d;
    logic [W-1:0] addend;
    logic [W-1:0] sum;
    logic         last;

    // The multiplier MSB row carries weight -2^(N-1), so it is subtracted.
    always_comb begin
        a_ext_d = a_ext_q;
        b_d     = b_q;
        acc_d   = acc_q;
        p_d     = p_q;
        last    = (cnt == CW'(N - 1));
        addend  = b_q[cnt] ? (a_ext_q << cnt) : '0;
        sum     = last ? (acc_q - addend) : (acc_q + addend);
        if (load_c) begin
            a_ext_d = W'($signed(a));
            b_d     = b;
            acc_d   = '0;
        end else if (step_c) begin
            acc_d = sum;
            if (last) begin
                p_d = sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_ext_q <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            p_q     <= '0;
        end else begin
            a_ext_q <= a_ext_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
        end
    end

    assign p = p_q;

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequential signed multiplier: IDLE/RUN/DONE handshake controller around mult_seq_dp.
module mult_seq_ctrl
    import mult_pkg::*;
#(
    parameter int unsigned M = M_DEF,
    parameter int unsigned N = N_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [M-1:0]    a,
    input  logic [N-1:0]    b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [M+N-1:0]  p,
    output logic            busy
);

    localparam int unsigned CW = $clog2(N);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          busy_q, busy_d;
    logic          load_c;
    logic          step_c;

    // Next state; flush overrides any transfer or handshake in the same cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_c  = 1'b0;
        step_c  = 1'b0;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        load_c  = 1'b1;
                        cnt_d   = '0;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    step_c = 1'b1;
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == CW'(N - 1)) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    mult_seq_dp #(
        .M  (M),
        .N  (N),
        .CW (CW)
    ) u_dp (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_c (load_c),
        .step_c (step_c),
        .a      (a),
        .b      (b),
        .cnt    (cnt_q),
        .p      (p)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Randomized scoreboard bench for mult_seq_ctrl against a plain signed-product model.
module tb_mult_seq_ctrl;

    localparam int unsigned M = 16;
    localparam int unsigned N = 16;
    localparam int unsigned W = M + N;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [M-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] p;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];

    mult_seq_ctrl #(.M(M), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_mul(input logic [M-1:0] x, input logic [N-1:0] y);
        longint prod;
        prod = longint'($signed(x)) * longint'($signed(y));
        return prod[W-1:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: handshakes and transfers are decided at the next rising edge, so sample on the falling one.
    always @(negedge clk) begin
        if (!rst_n || flush) begin
            exp_q.delete();
        end else begin
            if (out_valid === 1'b1) begin
                chk("out_valid_expected", 64'(exp_q.size() != 0), 64'd1);
                chk("busy_in_done", 64'(busy), 64'd1);
                chk("in_ready_in_done", 64'(in_ready), 64'd0);
                if (out_ready && exp_q.size() != 0) begin
                    chk("p_scoreboard", 64'(p), 64'(exp_q.pop_front()));
                end
            end
            if (in_valid && in_ready === 1'b1) begin
                exp_q.push_back(ref_mul(a, b));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [M-1:0] av, input logic [N-1:0] bv);
        int t = 0;
        while (in_ready !== 1'b1 && t < 50) begin
            tick();
            t++;
        end
        chk("accept_ready", 64'(in_ready), 64'd1);
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("busy_after_accept", 64'(busy), 64'd1);
    endtask

    // Runs from just after acceptance through the DONE handshake.
    task automatic finish(input logic [W-1:0] req_p, input bit check_p, input int hold);
        int lat = 0;
        logic [W-1:0] p0;
        while (out_valid !== 1'b1 && lat < 40) begin
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            a         = M'($urandom);
            b         = N'($urandom);
            tick();
            lat++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("latency", 64'(lat), 64'(N));
        p0 = p;
        if (check_p) chk("p_directed", 64'(p), 64'(req_p));
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_p", 64'(p), 64'(p0));
            chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = M'($urandom);
        b         = N'($urandom);
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("idle_after_hs", 64'(in_ready), 64'd1);
        chk("no_valid_after_hs", 64'(out_valid), 64'd0);
        chk("no_accept_on_hs", 64'(busy), 64'd0);
    endtask

    task automatic check_idle(input string name);
        chk({name, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({name, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({name, "_busy"}, 64'(busy), 64'd0);
    endtask

    function automatic logic [15:0] pick16();
        logic [15:0] corner[5];
        corner[0] = 16'h0000; corner[1] = 16'h0001; corner[2] = 16'hFFFF;
        corner[3] = 16'h8000; corner[4] = 16'h7FFF;
        if ($urandom_range(7) == 0) return corner[$urandom_range(4)];
        return 16'($urandom);
    endfunction

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        tick();
        check_idle("reset");
        chk("reset_p", 64'(p), 64'd0);
        rst_n = 1'b1;
        tick();

        start(16'd3, 16'd5);       finish(32'h0000000F, 1'b1, 0);
        start(16'hFFFD, 16'd5);    finish(32'hFFFFFFF1, 1'b1, 0);
        start(16'd5, 16'hFFFD);    finish(32'hFFFFFFF1, 1'b1, 1);
        start(16'h8000, 16'h8000); finish(32'h40000000, 1'b1, 0);
        start(16'h7FFF, 16'h8000); finish(32'hC0008000, 1'b1, 5);

        // Flush while cnt=7, then a clean -1 * -1.
        start(16'h1234, 16'h4321);
        repeat (7) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_idle("flush");
        for (int i = 0; i < int'(N) + 3; i++) begin
            tick();
            chk("flush_no_valid", 64'(out_valid), 64'd0);
        end
        start(16'hFFFF, 16'hFFFF); finish(32'h00000001, 1'b1, 0);

        // One-edge reset mid-RUN drops the operation.
        start(16'h0F0F, 16'h00FF);
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_idle("rst_run");
        chk("rst_run_p", 64'(p), 64'd0);
        for (int i = 0; i < int'(N) + 3; i++) begin
            tick();
            chk("rst_no_valid", 64'(out_valid), 64'd0);
        end

        for (int k = 0; k < 2000; k++) begin
            logic [15:0] ra, rb;
            ra = pick16();
            rb = pick16();
            start(ra, rb);
            finish(ref_mul(ra, rb), 1'b1, int'($urandom_range(2)));
        end

        tick();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
